mem_arbiter: RTL

Two-port arbiter sharing one single-ported unified memory between the pipeline's instruction-fetch (I) port and data-memory (D) port. It sits between the IF/MEM stages and the memory, and serializes their requests into one request/acknowledge memory transaction at a time. Each completed access is returned to its requester as a one-cycle ready pulse, which the pipeline uses as its stall-release. D has priority over I, with a bounded-starvation guard for I.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction-fetch (I) and data (D) requests onto one
// single-ported memory. D wins contention, but after STARVE_LIMIT consecutive
// contested D grants the waiting fetch is forced through. Every output is
// registered; each completed access returns a one-cycle ready pulse.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_n;
  logic [3:0]        starve_cnt, starve_cnt_n;
  logic              m_req_n, m_we_n, i_ready_n, d_ready_n, err_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [DATA_W-1:0] m_wdata_n, i_rdata_n, d_rdata_n;
  logic              grant_d, grant_i;

  // D wins unless I is also waiting and has already lost LIMIT times in a row.
  always_comb begin
    grant_d = d_req && !(i_req && (starve_cnt == LIMIT));
    grant_i = i_req && !grant_d;
  end

  // Next-state and next-output logic; everything is registered below.
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    m_req_n      = m_req;
    m_we_n       = m_we;
    m_addr_n     = m_addr;
    m_wdata_n    = m_wdata;
    i_ready_n    = 1'b0;
    d_ready_n    = 1'b0;
    i_rdata_n    = i_rdata;
    d_rdata_n    = d_rdata;
    err_n        = err;
    unique case (state)
      IDLE: begin
        // An ack with no access in flight carries no data; just flag it.
        if (m_ack) err_n = 1'b1;
        if (grant_d) begin
          // Only a contested D grant counts toward starving I.
          if (i_req) starve_cnt_n = starve_cnt + 4'd1;
          m_req_n   = 1'b1;
          m_we_n    = d_we;
          m_addr_n  = d_addr;
          m_wdata_n = d_wdata;
          state_n   = BUSY_D;
        end else if (grant_i) begin
          starve_cnt_n = 4'd0;
          m_req_n      = 1'b1;
          m_we_n       = 1'b0;
          m_addr_n     = i_addr;
          m_wdata_n    = '0;
          state_n      = BUSY_I;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          m_req_n   = 1'b0;
          m_we_n    = 1'b0;
          i_rdata_n = m_rdata;
          i_ready_n = 1'b1;
          state_n   = RESP;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          m_req_n   = 1'b0;
          m_we_n    = 1'b0;
          // Stores leave the load result untouched.
          if (!m_we) d_rdata_n = m_rdata;
          d_ready_n = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        // Gap cycle so the requester can drop or replace its request.
        if (m_ack) err_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      m_req      <= m_req_n;
      m_we       <= m_we_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      i_ready    <= i_ready_n;
      d_ready    <= d_ready_n;
      i_rdata    <= i_rdata_n;
      d_rdata    <= d_rdata_n;
      err        <= err_n;
    end
  end

endmodule
